// File: rtl/nes_joypad_port_if.sv
// ============================================================================
// nes_joypad_port_if : CPU-side bus bundle for the $4016/$4017 controller ports
// Revision: 1.0
// ============================================================================
`default_nettype none

interface nes_joypad_port_if;
    logic [15:0] i_address;
    logic        i_rw;
    logic [7:0]  i_data;
    logic [7:0]  o_data;
    logic        o_data_en;

    modport master (
        output i_address,
        output i_rw,
        output i_data,
        input  o_data,
        input  o_data_en
    );

    modport slave (
        input  i_address,
        input  i_rw,
        input  i_data,
        output o_data,
        output o_data_en
    );
endinterface

`default_nettype wire

// File: rtl/nes_joypad_port.sv
// ============================================================================
// nes_joypad_port : strobe latch and two serial shift registers for NES pads
// Revision: 1.0
// ============================================================================
`default_nettype none

module nes_joypad_port #(
    parameter logic [15:0] BASE_ADDR = 16'h4016,
    parameter logic [7:0]  OPEN_BUS  = 8'h40
) (
    input  wire logic           i_clk,
    input  wire logic           i_reset,
    input  wire logic           i_clk_en,
    nes_joypad_port_if.slave    bus,
    output logic                o_strobe,
    input  wire logic [7:0]     i_pad1_buttons,
    input  wire logic [7:0]     i_pad2_buttons
);

    logic       strobe_q, strobe_d;
    logic [7:0] shift1_q, shift1_d;
    logic [7:0] shift2_q, shift2_d;

    logic w_sel1, w_sel2, w_read, w_wr1, w_load;
    logic w_bit1, w_bit2;
    logic [6:0] w_unused_data;

    assign w_sel1 = (bus.i_address == BASE_ADDR);
    assign w_sel2 = (bus.i_address == (BASE_ADDR + 16'd1));
    assign w_read = bus.i_rw & (w_sel1 | w_sel2);
    assign w_wr1  = ~bus.i_rw & w_sel1;
    // The edge that clears strobe still reloads, since the pre-edge strobe is 1.
    assign w_load = strobe_q | (w_wr1 & bus.i_data[0]);

    assign w_bit1 = strobe_q ? i_pad1_buttons[0] : shift1_q[0];
    assign w_bit2 = strobe_q ? i_pad2_buttons[0] : shift2_q[0];
    assign w_unused_data = bus.i_data[7:1];

    always_comb begin
        bus.o_data    = 8'h00;
        bus.o_data_en = 1'b0;
        if (w_read) begin
            bus.o_data_en = 1'b1;
            bus.o_data    = {OPEN_BUS[7:1], (w_sel1 ? w_bit1 : w_bit2)};
        end
    end

    always_comb begin
        strobe_d = strobe_q;
        shift1_d = shift1_q;
        shift2_d = shift2_q;
        if (i_clk_en) begin
            if (w_wr1) begin
                strobe_d = bus.i_data[0];
            end
            if (w_load) begin
                shift1_d = i_pad1_buttons;
                shift2_d = i_pad2_buttons;
            end else if (w_read) begin
                // Shift in 1s so an exhausted register keeps reading 1.
                if (w_sel1) shift1_d = {1'b1, shift1_q[7:1]};
                if (w_sel2) shift2_d = {1'b1, shift2_q[7:1]};
            end
        end
    end

    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            strobe_q <= 1'b0;
            shift1_q <= 8'hFF;
            shift2_q <= 8'hFF;
        end else begin
            strobe_q <= strobe_d;
            shift1_q <= shift1_d;
            shift2_q <= shift2_d;
        end
    end

    assign o_strobe = strobe_q;

endmodule

`default_nettype wire
